hub75_bcm_scan: RTL and testbench



---
 rtl/hub75_bcm_scan.sv | 214 +++++++++++++++++++++
 tb/tb_hub75_bcm_scan.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_bcm_scan.sv
// HUB75 LED-matrix scan engine with binary code modulation.
// Per pass: fetch pixel pairs of one row, shift one bit plane into the panel,
// latch it, then light it for BASE_T << plane cycles. Planes advance first,
// then rows; the whole sequence repeats while en stays high.
module hub75_bcm_scan #(
    parameter int unsigned COLS       = 64,
    parameter int unsigned ROW_ADDR_W = 4,
    parameter int unsigned BPC        = 4,
    parameter int unsigned HALF       = 1,
    parameter int unsigned BASE_T     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    output logic                                 fb_rd,
    output logic [ROW_ADDR_W+$clog2(COLS)-1:0]   fb_addr,
    input  logic [6*BPC-1:0]                     fb_data,
    output logic [1:0]                           mat_r,
    output logic [1:0]                           mat_g,
    output logic [1:0]                           mat_b,
    output logic [ROW_ADDR_W-1:0]                mat_row,
    output logic                                 mat_clk,
    output logic                                 mat_lat,
    output logic                                 mat_oe_n,
    output logic                                 frame_start
);

    localparam int unsigned COL_W   = $clog2(COLS);
    localparam int unsigned AW      = ROW_ADDR_W + COL_W;
    localparam int unsigned PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int unsigned DISP_W  = $clog2(BASE_T << (BPC - 1)) + 1;
    localparam int unsigned SLOT_W  = $clog2(2 * HALF) + 1;
    // One counter serves both the slot phase and the display time.
    localparam int unsigned CNT_W   = (DISP_W > SLOT_W) ? DISP_W : SLOT_W;

    localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(2 * HALF - 1);
    localparam logic [CNT_W-1:0]   HALF_CNT   = CNT_W'(HALF);
    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BPC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StLatch,
        StDisplay
    } state_e;

    state_e                r_state, w_state;
    logic [ROW_ADDR_W-1:0] r_row, w_row;
    logic [PLANE_W-1:0]    r_plane, w_plane;
    logic [COL_W-1:0]      r_col, w_col;
    logic [CNT_W-1:0]      r_cnt, w_cnt;

    logic                  r_fb_rd, w_fb_rd;
    logic [AW-1:0]         r_fb_addr, w_fb_addr;
    logic [1:0]            r_mat_r, w_mat_r;
    logic [1:0]            r_mat_g, w_mat_g;
    logic [1:0]            r_mat_b, w_mat_b;
    logic [ROW_ADDR_W-1:0] r_mat_row, w_mat_row;
    logic                  r_mat_clk, w_mat_clk;
    logic                  r_mat_lat, w_mat_lat;
    logic                  r_mat_oe_n, w_mat_oe_n;
    logic                  r_frame_start, w_frame_start;

    logic                  w_load;
    logic [COL_W-1:0]      w_col_inc;
    logic [CNT_W-1:0]      w_disp_last;
    logic [6*BPC-1:0]      w_fb_sh;

    assign w_col_inc   = r_col + COL_W'(1);
    assign w_disp_last = (CNT_W'(BASE_T) << r_plane) - CNT_W'(1);
    // Bit [plane] of every colour field lands at a fixed offset after this shift.
    assign w_fb_sh     = fb_data >> r_plane;

    // Next state, indices and registered outputs for the state being entered.
    always_comb begin
        w_state       = r_state;
        w_row         = r_row;
        w_plane       = r_plane;
        w_col         = r_col;
        w_cnt         = r_cnt;
        w_fb_rd       = 1'b0;
        w_fb_addr     = r_fb_addr;
        w_mat_r       = r_mat_r;
        w_mat_g       = r_mat_g;
        w_mat_b       = r_mat_b;
        w_mat_row     = r_mat_row;
        w_mat_clk     = 1'b0;
        w_mat_lat     = 1'b0;
        w_mat_oe_n    = 1'b1;
        w_frame_start = 1'b0;
        w_load        = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (en) begin
                    w_state = StFetch;
                end
            end
            StFetch: begin
                w_state = StShift;
                w_col   = '0;
                w_cnt   = '0;
                w_load  = 1'b1;
            end
            StShift: begin
                if (r_cnt == SLOT_LAST) begin
                    w_cnt = '0;
                    if (r_col == COL_LAST) begin
                        w_state   = StLatch;
                        w_mat_lat = 1'b1;
                        w_mat_row = r_row;
                    end else begin
                        w_col  = w_col_inc;
                        w_load = 1'b1;
                    end
                end else begin
                    w_cnt     = r_cnt + CNT_W'(1);
                    w_mat_clk = (w_cnt >= HALF_CNT);
                    // Request the next pixel pair so it arrives as the next slot opens.
                    if ((w_cnt == SLOT_LAST) && (r_col != COL_LAST)) begin
                        w_fb_rd   = 1'b1;
                        w_fb_addr = {r_row, w_col_inc};
                    end
                end
            end
            StLatch: begin
                w_state    = StDisplay;
                w_cnt      = '0;
                w_mat_oe_n = 1'b0;
            end
            StDisplay: begin
                if (r_cnt == w_disp_last) begin
                    w_cnt = '0;
                    if (r_plane == PLANE_LAST) begin
                        w_plane = '0;
                        w_row   = r_row + ROW_ADDR_W'(1);
                    end else begin
                        w_plane = r_plane + PLANE_W'(1);
                    end
                    w_state = en ? StFetch : StIdle;
                end else begin
                    w_cnt      = r_cnt + CNT_W'(1);
                    w_mat_oe_n = 1'b0;
                end
            end
            default: begin
                w_state = StIdle;
            end
        endcase

        if (w_state == StFetch) begin
            w_fb_rd       = 1'b1;
            w_fb_addr     = {w_row, COL_W'(0)};
            w_frame_start = (w_row == '0) && (w_plane == '0);
        end

        if (w_load) begin
            w_mat_r = {w_fb_sh[3*BPC], w_fb_sh[0]};
            w_mat_g = {w_fb_sh[4*BPC], w_fb_sh[BPC]};
            w_mat_b = {w_fb_sh[5*BPC], w_fb_sh[2*BPC]};
        end
    end

    // State, indices and output registers; reset forces the panel dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_row         <= '0;
            r_plane       <= '0;
            r_col         <= '0;
            r_cnt         <= '0;
            r_fb_rd       <= 1'b0;
            r_fb_addr     <= '0;
            r_mat_r       <= '0;
            r_mat_g       <= '0;
            r_mat_b       <= '0;
            r_mat_row     <= '0;
            r_mat_clk     <= 1'b0;
            r_mat_lat     <= 1'b0;
            r_mat_oe_n    <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_row         <= w_row;
            r_plane       <= w_plane;
            r_col         <= w_col;
            r_cnt         <= w_cnt;
            r_fb_rd       <= w_fb_rd;
            r_fb_addr     <= w_fb_addr;
            r_mat_r       <= w_mat_r;
            r_mat_g       <= w_mat_g;
            r_mat_b       <= w_mat_b;
            r_mat_row     <= w_mat_row;
            r_mat_clk     <= w_mat_clk;
            r_mat_lat     <= w_mat_lat;
            r_mat_oe_n    <= w_mat_oe_n;
            r_frame_start <= w_frame_start;
        end
    end

    assign fb_rd       = r_fb_rd;
    assign fb_addr     = r_fb_addr;
    assign mat_r       = r_mat_r;
    assign mat_g       = r_mat_g;
    assign mat_b       = r_mat_b;
    assign mat_row     = r_mat_row;
    assign mat_clk     = r_mat_clk;
    assign mat_lat     = r_mat_lat;
    assign mat_oe_n    = r_mat_oe_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Bench for hub75_bcm_scan: two instances (HALF=1 and HALF=3) checked cycle by
// cycle against a schedule computed from pass offsets and framebuffer contents.
module tb_hub75_bcm_scan;

    localparam int COLS   = 4;
    localparam int RAW    = 1;
    localparam int BPC    = 2;
    localparam int BASE_T = 2;
    localparam int HALF_A = 1;
    localparam int HALF_B = 3;
    localparam int AW     = RAW + $clog2(COLS);
    localparam int DW     = 6 * BPC;
    localparam int OW     = 1 + AW + 6 + RAW + 4;
    // Packed observation with only mat_oe_n high (bit 1).
    localparam logic [OW-1:0] RST_OBS = OW'(2);

    logic clk, rst, en_a, en_b;

    logic          fb_rd_a, fb_rd_b;
    logic [AW-1:0] fb_addr_a, fb_addr_b;
    logic [DW-1:0] fb_data_a, fb_data_b;
    logic [1:0]    r_a, g_a, b_a, r_b, g_b, b_b;
    logic [RAW-1:0] row_a, row_b;
    logic          clk_a, lat_a, oe_a, fs_a;
    logic          clk_b, lat_b, oe_b, fs_b;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            lrow [2];
    int            sel;
    int            n_tests, n_fail;

    logic [OW-1:0] obs_a, obs_b, obs;
    logic          o_fb_rd, o_clk, o_lat, o_oe, o_fs;
    logic [AW-1:0] o_fb_addr;
    logic [1:0]    o_r, o_g, o_b;
    logic [RAW-1:0] o_row;

    hub75_bcm_scan #(
        .COLS(COLS), .ROW_ADDR_W(RAW), .BPC(BPC), .HALF(HALF_A), .BASE_T(BASE_T)
    ) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a),
        .fb_rd(fb_rd_a), .fb_addr(fb_addr_a), .fb_data(fb_data_a),
        .mat_r(r_a), .mat_g(g_a), .mat_b(b_a), .mat_row(row_a),
        .mat_clk(clk_a), .mat_lat(lat_a), .mat_oe_n(oe_a), .frame_start(fs_a)
    );

    hub75_bcm_scan #(
        .COLS(COLS), .ROW_ADDR_W(RAW), .BPC(BPC), .HALF(HALF_B), .BASE_T(BASE_T)
    ) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b),
        .fb_rd(fb_rd_b), .fb_addr(fb_addr_b), .fb_data(fb_data_b),
        .mat_r(r_b), .mat_g(g_b), .mat_b(b_b), .mat_row(row_b),
        .mat_clk(clk_b), .mat_lat(lat_b), .mat_oe_n(oe_b), .frame_start(fs_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer: data for a read is on fb_data at the edge ending the fb_rd cycle.
    always @(negedge clk) begin
        fb_data_a <= fb_rd_a ? mem[fb_addr_a] : {DW{1'bx}};
        fb_data_b <= fb_rd_b ? mem[fb_addr_b] : {DW{1'bx}};
    end

    assign obs_a = {fb_rd_a, fb_addr_a, r_a, g_a, b_a, row_a, clk_a, lat_a, oe_a, fs_a};
    assign obs_b = {fb_rd_b, fb_addr_b, r_b, g_b, b_b, row_b, clk_b, lat_b, oe_b, fs_b};
    assign obs   = (sel == 1) ? obs_b : obs_a;
    assign {o_fb_rd, o_fb_addr, o_r, o_g, o_b, o_row, o_clk, o_lat, o_oe, o_fs} = obs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d t=%0t: got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_fb_rd"}, 32'(o_fb_rd), 0);
        chk({tag, "_clk"}, 32'(o_clk), 0);
        chk({tag, "_lat"}, 32'(o_lat), 0);
        chk({tag, "_oe_n"}, 32'(o_oe), 1);
        chk({tag, "_fs"}, 32'(o_fs), 0);
        chk({tag, "_row"}, 32'(o_row), lrow[sel]);
    endtask

    // Expected outputs at offset k of a pass: 0 fetch, 1..COLS*2*half shift slots,
    // then one latch cycle and BASE_T<<p display cycles. Entered on the fetch cycle.
    task automatic check_pass(input int half, input int r, input int p,
                              input int stop_k, input int drop_k);
        int shift_len, period, c, ph;
        logic e_rd, e_clk, e_lat, e_oe, e_fs, shifting;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] px;
        shift_len = COLS * 2 * half;
        period    = 2 + shift_len + (BASE_T << p);
        for (int k = 0; k < period; k++) begin
            if (k > 0) step();
            if (k == drop_k) begin
                if (sel == 0) en_a = 1'b0;
                else en_b = 1'b0;
            end
            e_rd = 0; e_addr = '0; e_clk = 0; e_lat = 0; e_oe = 1; e_fs = 0;
            shifting = 0; px = '0;
            if (k == 0) begin
                e_rd   = 1;
                e_addr = AW'(r * COLS);
                e_fs   = (r == 0) && (p == 0);
            end else if (k <= shift_len) begin
                c        = (k - 1) / (2 * half);
                ph       = (k - 1) % (2 * half);
                e_clk    = (ph >= half);
                shifting = 1;
                px       = mem[r * COLS + c];
                if ((ph == 2 * half - 1) && (c < COLS - 1)) begin
                    e_rd   = 1;
                    e_addr = AW'(r * COLS + c + 1);
                end
            end else if (k == shift_len + 1) begin
                e_lat     = 1;
                lrow[sel] = r;
            end else begin
                e_oe = 0;
            end
            chk("fb_rd", 32'(o_fb_rd), 32'(e_rd));
            if (e_rd) chk("fb_addr", 32'(o_fb_addr), 32'(e_addr));
            chk("mat_clk", 32'(o_clk), 32'(e_clk));
            chk("mat_lat", 32'(o_lat), 32'(e_lat));
            chk("mat_oe_n", 32'(o_oe), 32'(e_oe));
            chk("frame_start", 32'(o_fs), 32'(e_fs));
            chk("mat_row", 32'(o_row), lrow[sel]);
            if (shifting) begin
                chk("mat_r", 32'(o_r), 32'({px[3*BPC+p], px[p]}));
                chk("mat_g", 32'(o_g), 32'({px[4*BPC+p], px[BPC+p]}));
                chk("mat_b", 32'(o_b), 32'({px[5*BPC+p], px[2*BPC+p]}));
            end
            if (k == stop_k) break;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 0;
        rst     = 1'b1;
        en_a    = 1'b0;
        en_b    = 1'b0;
        lrow[0] = 0;
        lrow[1] = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        repeat (2) step();
        chk("reset_a", 32'(obs), 32'(RST_OBS));
        sel = 1;
        #1;
        chk("reset_b", 32'(obs), 32'(RST_OBS));
        sel = 0;

        // Frame 0: only top red = 2'b10 at row 0, col 1.
        mem[1] = DW'(2);
        rst  = 1'b0;
        en_a = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < BPC; p++) begin
                step();
                check_pass(HALF_A, r, p, -1, -1);
            end

        // Frames 1-2: random pixels, row wrap.
        for (int f = 0; f < 2; f++) begin
            rand_mem();
            for (int r = 0; r < 2; r++)
                for (int p = 0; p < BPC; p++) begin
                    step();
                    check_pass(HALF_A, r, p, -1, -1);
                end
        end

        // Frame 3: drop en while shifting row 1 plane 0; the plane still completes.
        rand_mem();
        step(); check_pass(HALF_A, 0, 0, -1, -1);
        step(); check_pass(HALF_A, 0, 1, -1, -1);
        step(); check_pass(HALF_A, 1, 0, -1, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("idle_after_drop");
        end
        en_a = 1'b1;
        step(); check_pass(HALF_A, 1, 1, -1, -1);

        // Reset in the first display cycle of row 0 plane 0.
        step(); check_pass(HALF_A, 0, 0, COLS * 2 * HALF_A + 2, -1);
        rst = 1'b1;
        lrow[0] = 0;
        #1;
        chk("rst_async", 32'(obs), 32'(RST_OBS));
        step();
        chk("rst_hold", 32'(obs), 32'(RST_OBS));
        rst = 1'b0;
        step(); check_pass(HALF_A, 0, 0, -1, -1);
        step(); check_pass(HALF_A, 0, 1, -1, -1);
        en_a = 1'b0;
        step();
        check_idle("idle_a_end");

        // Second instance, HALF=3: one frame plus the wrap back to row 0.
        sel = 1;
        rand_mem();
        en_b = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < BPC; p++) begin
                step();
                check_pass(HALF_B, r, p, -1, -1);
            end
        step(); check_pass(HALF_B, 0, 0, -1, -1);
        en_b = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
